// File: rtl/divider_arbiter.sv
// rtl/divider_arbiter.sv - round-robin arbiter sharing one slow unsigned divider across NUM_REQ requesters
// Define DIV_ARB_TIMEOUT_EN to add a BUSY-state watchdog of TIMEOUT cycles.
module divider_arbiter #(
  parameter int DIVIDEND_BITS = 10,
  parameter int DIVISOR_BITS  = 7,
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT       = 64,
  localparam int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               in_valid,
  output logic [NUM_REQ-1:0]               in_ready,
  input  logic [NUM_REQ*DIVIDEND_BITS-1:0] in_dividend,
  input  logic [NUM_REQ*DIVISOR_BITS-1:0]  in_divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ID_BITS-1:0]               out_id,
  output logic [DIVIDEND_BITS-1:0]         out_quotient,
  output logic [DIVISOR_BITS-1:0]          out_remainder,
  output logic                             out_error,
  output logic                             div_in_valid,
  output logic [DIVIDEND_BITS-1:0]         div_dividend,
  output logic [DIVISOR_BITS-1:0]          div_divisor,
  input  logic [DIVIDEND_BITS-1:0]         div_quotient,
  input  logic [DIVISOR_BITS-1:0]          div_remainder,
  input  logic                             div_error,
  input  logic                             div_out_valid
);

  localparam int IW = ID_BITS + 1;
  localparam logic [IW-1:0] NREQ_W = IW'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_params
    $error("divider_arbiter: unsupported parameter values");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, next_state;
  logic [ID_BITS-1:0]  rr_ptr, grant_id;
  logic [IW-1:0]       idx;
  logic                grant_any;
  logic                timeout_hit;

  // Scan offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (in_valid[idx[ID_BITS-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx[ID_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = '0;
    case (state)
      IDLE: if (grant_any) begin
        in_ready   = NUM_REQ'(1) << grant_id;
        next_state = BUSY;
      end
      BUSY: if (div_out_valid || timeout_hit) next_state = RESP;
      RESP: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      div_in_valid  <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      out_valid     <= 1'b0;
      out_id        <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_error     <= 1'b0;
    end else begin
      div_in_valid <= 1'b0;
      case (state)
        IDLE: if (grant_any) begin
          div_dividend <= in_dividend[grant_id*DIVIDEND_BITS +: DIVIDEND_BITS];
          div_divisor  <= in_divisor[grant_id*DIVISOR_BITS +: DIVISOR_BITS];
          out_id       <= grant_id;
          rr_ptr       <= (grant_id == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          div_in_valid <= 1'b1;
        end
        BUSY: if (div_out_valid) begin
          out_quotient  <= div_quotient;
          out_remainder <= div_remainder;
          out_error     <= div_error;
          out_valid     <= 1'b1;
        end else if (timeout_hit) begin
          out_quotient  <= '0;
          out_remainder <= '0;
          out_error     <= 1'b1;
          out_valid     <= 1'b1;
        end
        RESP: if (out_ready) out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;

  // Counts BUSY cycles starting from the issue cycle; a real result on the last cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (state != BUSY)  to_cnt <= '0;
    else                     to_cnt <= to_cnt + 16'd1;
  end

  assign timeout_hit = (state == BUSY) && !div_out_valid && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// tb/tb_divider_arbiter.sv - scoreboard bench for divider_arbiter with a behavioural slow-divider stub
// Build with DIV_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_divider_arbiter;
  localparam int DD = 10;
  localparam int DV = 7;
  localparam int N = 4;
  localparam int IDB = 2;
  localparam int TB_TIMEOUT = 8;
  localparam int DIV_LAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_ready;
  logic [N*DD-1:0] in_dividend = '0;
  logic [N*DV-1:0] in_divisor = '0;
  logic out_valid, out_error, div_in_valid;
  logic out_ready = 1'b1;
  logic [IDB-1:0] out_id;
  logic [DD-1:0] out_quotient, div_dividend, div_quotient;
  logic [DV-1:0] out_remainder, div_divisor, div_remainder;
  logic div_error, div_out_valid;

  divider_arbiter #(.DIVIDEND_BITS(DD), .DIVISOR_BITS(DV), .NUM_REQ(N), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_error(out_error), .div_in_valid(div_in_valid),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_error(div_error), .div_out_valid(div_out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider stub: answers DIV_LAT cycles after the issue pulse unless muted; spur injects a stray pulse.
  bit mute = 0;
  bit spur = 0;
  bit stub_busy;
  int stub_cnt;
  logic [DD-1:0] stub_a;
  logic [DV-1:0] stub_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_out_valid <= 1'b0; div_quotient <= '0; div_remainder <= '0; div_error <= 1'b0;
      stub_busy <= 1'b0; stub_cnt <= 0; stub_a <= '0; stub_b <= '0;
    end else begin
      div_out_valid <= 1'b0;
      if (div_in_valid) begin
        stub_busy <= 1'b1; stub_cnt <= DIV_LAT - 2; stub_a <= div_dividend; stub_b <= div_divisor;
      end else if (stub_busy) begin
        if (stub_cnt == 0) begin
          stub_busy <= 1'b0;
          if (!mute) begin
            div_out_valid <= 1'b1;
            div_error     <= (stub_b == 0);
            div_quotient  <= (stub_b == 0) ? '1 : DD'(stub_a / stub_b);
            div_remainder <= (stub_b == 0) ? '1 : DV'(stub_a % stub_b);
          end
        end else stub_cnt <= stub_cnt - 1;
      end
      if (spur) begin
        div_out_valid <= 1'b1; div_quotient <= 10'h155; div_remainder <= 7'h2a; div_error <= 1'b1;
      end
    end
  end

  // Reference model: one transaction at a time, round-robin from a pointer, results by plain arithmetic.
  typedef struct { int id; int q; int r; bit err; bit cmp_qr; } exp_t;
  exp_t exp_q[$];
  bit m_busy = 0;
  int m_ptr = 0;
  int m_lat = 0;
  int cyc = 0;
  int grant_cyc = -10;
  bit held = 0;
  logic [63:0] snap;
  logic [N-1:0] hs_last = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {in_ready, out_valid, out_id, out_quotient, out_remainder, out_error,
                            div_in_valid, div_dividend, div_divisor}, 64'd0);
      exp_q.delete(); m_busy = 0; m_ptr = 0; held = 0; grant_cyc = -10; hs_last = '0;
    end else begin
      hs_last = in_valid & in_ready;
      if (!m_busy && in_valid != 0) begin
        int g;
        exp_t e;
        int a, b;
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        chk("grant", in_ready, 64'd1 << g);
        a = int'(in_dividend[g*DD +: DD]);
        b = int'(in_divisor[g*DV +: DV]);
        e.id = g;
        if (mute) begin e.q = 0; e.r = 0; e.err = 1; e.cmp_qr = 1; m_lat = TB_TIMEOUT + 1; end
        else if (b == 0) begin e.q = 0; e.r = 0; e.err = 1; e.cmp_qr = 0; m_lat = DIV_LAT + 2; end
        else begin e.q = a / b; e.r = a % b; e.err = 0; e.cmp_qr = 1; m_lat = DIV_LAT + 2; end
        exp_q.push_back(e);
        m_ptr = (g + 1) % N;
        m_busy = 1;
        grant_cyc = cyc;
      end else begin
        chk("no_grant", in_ready, 64'd0);
      end
      chk("div_in_valid", div_in_valid, 64'(m_busy && cyc == grant_cyc + 1));
      if (out_valid) begin
        if (!held) begin
          chk("latency", cyc - grant_cyc, m_lat);
          snap = {out_id, out_quotient, out_remainder, out_error};
          held = 1;
        end else begin
          chk("out_stable", {out_id, out_quotient, out_remainder, out_error}, snap);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_response", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_id", out_id, e.id);
            chk("out_error", out_error, e.err);
            if (e.cmp_qr) begin
              chk("out_quotient", out_quotient, e.q);
              chk("out_remainder", out_remainder, e.r);
            end
          end
          m_busy = 0;
          held = 0;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = in_valid & ~hs_last;
  endtask

  task automatic req(input int i, input int a, input int b);
    in_dividend[i*DD +: DD] = DD'(a);
    in_divisor[i*DV +: DV] = DV'(b);
    in_valid[i] = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_busy || in_valid != 0) && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    in_valid = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ids[$];
    int n;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1
    req(0, 800, 23);
    drain();

    // T2: all four held; expect grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) req(i, $urandom_range(1023), $urandom_range(127, 1));
    n = 0;
    while (ids.size() < 5 && n < 400) begin
      tick(); n++;
      for (int i = 0; i < N; i++)
        if (hs_last[i]) begin
          ids.push_back(i);
          if (ids.size() < 5) req(i, $urandom_range(1023), $urandom_range(127, 1));
        end
    end
    chk("t2_grant_count", ids.size(), 5);
    for (int i = 0; i < ids.size(); i++) chk("t2_grant_order", ids[i], i % N);
    in_valid = '0;
    drain();

    // T3
    req(2, 100, 0);
    drain();
    req(3, 256, 2);
    drain();

    // T4: backpressure with a stray divider pulse and competing requests
    out_ready = 1'b0;
    req(1, $urandom_range(1023), $urandom_range(127, 1));
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("t4_reached_resp", out_valid, 1);
    req(0, 77, 5); req(2, 999, 100);
    for (int i = 0; i < 20; i++) begin
      spur = (i == 5);
      tick();
    end
    spur = 0;
    out_ready = 1'b1;
    drain();

    // T5: reset two cycles after grant
    req(0, 300, 7);
    n = 0;
    while (hs_last == 0 && n < 20) begin tick(); n++; end
    tick(); tick();
    do_reset();
    req(2, 470, 12);
    drain();

`ifdef DIV_ARB_TIMEOUT_EN
    // T6: divider never answers
    mute = 1;
    req(1, 500, 9);
    drain();
    mute = 0;
    req(3, 123, 10);
    drain();
`endif

    // Random traffic
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(3) == 0)
          req(i, $urandom_range(1023), ($urandom_range(7) == 0) ? 0 : $urandom_range(127, 1));
        else if (in_valid[i] && $urandom_range(31) == 0)
          in_valid[i] = 1'b0;
      end
      out_ready = ($urandom_range(2) != 0);
      tick();
    end
    out_ready = 1'b1;
    in_valid = '0;
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
